// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter that time-shares one start/done 16x16 multiplier between NREQ requesters.
// Each op runs CLEAR (multiplier reset), START, WAIT (with timeout) and RESP (result to requester).
module mult_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 65600
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic [NREQ-1:0]      req,
   input  logic [16*NREQ-1:0]   req_arg1,
   input  logic [16*NREQ-1:0]   req_arg2,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_product,
   output logic                 rsp_err,
   output logic                 busy,
   output logic                 mul_res_n,
   output logic                 mul_start,
   output logic [15:0]          mul_arg1,
   output logic [15:0]          mul_arg2,
   input  logic                 mul_done,
   input  logic [31:0]          mul_product
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [CNT_W-1:0]   cnt;
   logic               nxt_found;
   logic [PTR_W-1:0]   nxt_idx;
   logic [PTR_W-1:0]   cand;

   function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      return NREQ'(1) << idx;
   endfunction

   // Search starts one past the last served requester so it ends up lowest priority.
   always_comb begin
      nxt_found = 1'b0;
      nxt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PTR_W'((int'(ptr) + k) % NREQ);
         if (!nxt_found && req[cand]) begin
            nxt_found = 1'b1;
            nxt_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state       <= S_IDLE;
         ptr         <= PTR_W'(NREQ - 1);
         cnt         <= '0;
         gnt         <= '0;
         rsp_valid   <= '0;
         rsp_product <= '0;
         rsp_err     <= 1'b0;
         busy        <= 1'b0;
         mul_res_n   <= 1'b0;
         mul_start   <= 1'b0;
         mul_arg1    <= '0;
         mul_arg2    <= '0;
      end else begin
         rsp_valid <= '0;
         mul_start <= 1'b0;
         mul_res_n <= 1'b1;
         case (state)
            S_IDLE: begin
               if (nxt_found) begin
                  state     <= S_CLEAR;
                  ptr       <= nxt_idx;
                  gnt       <= onehot(nxt_idx);
                  busy      <= 1'b1;
                  mul_res_n <= 1'b0;
                  mul_arg1  <= req_arg1[16*nxt_idx +: 16];
                  mul_arg2  <= req_arg2[16*nxt_idx +: 16];
               end
            end
            S_CLEAR: begin
               state     <= S_START;
               mul_start <= 1'b1;
            end
            S_START: begin
               state <= S_WAIT;
               cnt   <= '0;
            end
            S_WAIT: begin
               // done wins over a timeout landing on the same cycle
               if (mul_done) begin
                  state       <= S_RESP;
                  rsp_product <= mul_product;
                  rsp_err     <= 1'b0;
                  rsp_valid   <= onehot(ptr);
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state       <= S_RESP;
                  rsp_product <= '0;
                  rsp_err     <= 1'b1;
                  rsp_valid   <= onehot(ptr);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               gnt     <= '0;
               busy    <= 1'b0;
               rsp_err <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               gnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural start/done multiplier stub.
module tb_mult_share_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 20;

   logic                clk = 1'b0;
   logic                res;
   logic [NREQ-1:0]     req;
   logic [16*NREQ-1:0]  req_arg1;
   logic [16*NREQ-1:0]  req_arg2;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rsp_valid;
   logic [31:0]         rsp_product;
   logic                rsp_err;
   logic                busy;
   logic                mul_res_n;
   logic                mul_start;
   logic [15:0]         mul_arg1;
   logic [15:0]         mul_arg2;
   logic                mul_done;
   logic [31:0]         mul_product;

   int tests = 0;
   int fails = 0;

   logic stub_never;
   logic m_busy;
   int   lat_cnt;

   mult_share_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .res(res), .req(req), .req_arg1(req_arg1), .req_arg2(req_arg2),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
      .busy(busy), .mul_res_n(mul_res_n), .mul_start(mul_start), .mul_arg1(mul_arg1),
      .mul_arg2(mul_arg2), .mul_done(mul_done), .mul_product(mul_product)
   );

   always #5 clk = ~clk;

   // Multiplier stub: done rises a few cycles after start and holds until mul_res_n is low.
   always @(posedge clk) begin
      if (!mul_res_n) begin
         mul_done    <= 1'b0;
         mul_product <= 32'd0;
         m_busy      <= 1'b0;
         lat_cnt     <= 0;
      end else if (mul_start) begin
         m_busy  <= 1'b1;
         lat_cnt <= 2;
      end else if (m_busy && !stub_never) begin
         if (lat_cnt == 0) begin
            mul_done    <= 1'b1;
            mul_product <= 32'(mul_arg1) * 32'(mul_arg2);
            m_busy      <= 1'b0;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
      req[i]            = v;
      req_arg1[16*i+:16] = a;
      req_arg2[16*i+:16] = b;
   endtask

   task automatic wait_rsp(input int limit, output int cyc, output bit got, output bit bad_gnt);
      cyc = 0; got = 1'b0; bad_gnt = 1'b0;
      while (!got && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (busy ? !$onehot(gnt) : (gnt != '0)) bad_gnt = 1'b1;
         if (rsp_valid != '0) got = 1'b1;
      end
   endtask

   task automatic wait_start(input int limit, output bit got);
      int cyc;
      cyc = 0; got = mul_start;
      while (!got && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (mul_start) got = 1'b1;
      end
   endtask

   task automatic pulse_reset();
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      res = 1'b1; req = '0; req_arg1 = '0; req_arg2 = '0;
      repeat (3) @(negedge clk);
      tests++; if (gnt !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL reset_ctrl gnt=%b rsp_valid=%b busy=%b expected 0/0/0", gnt, rsp_valid, busy); end
      tests++; if (mul_res_n !== 1'b0 || mul_start !== 1'b0) begin
         fails++; $display("FAIL reset_mul mul_res_n=%b mul_start=%b expected 0/0", mul_res_n, mul_start); end
      tests++; if (rsp_product !== 32'd0 || rsp_err !== 1'b0 || mul_arg1 !== 16'd0 || mul_arg2 !== 16'd0) begin
         fails++; $display("FAIL reset_data prod=%h err=%b a1=%h a2=%h expected zeros", rsp_product, rsp_err, mul_arg1, mul_arg2); end
      res = 1'b0;
      @(negedge clk);
      tests++; if (mul_res_n !== 1'b1) begin
         fails++; $display("FAIL idle_res_n got=%b expected 1", mul_res_n); end
   endtask

   task automatic test_single();
      int cyc; bit got, bad;
      set_req(0, 1'b1, 16'd3, 16'd4);
      @(negedge clk);
      tests++; if (gnt !== 4'b0001 || busy !== 1'b1 || mul_res_n !== 1'b0 || mul_start !== 1'b0) begin
         fails++; $display("FAIL single_clear gnt=%b busy=%b res_n=%b start=%b expected 0001/1/0/0", gnt, busy, mul_res_n, mul_start); end
      @(negedge clk);
      tests++; if (mul_start !== 1'b1 || mul_res_n !== 1'b1 || mul_arg1 !== 16'd3 || mul_arg2 !== 16'd4) begin
         fails++; $display("FAIL single_start start=%b res_n=%b a1=%0d a2=%0d expected 1/1/3/4", mul_start, mul_res_n, mul_arg1, mul_arg2); end
      @(negedge clk);
      tests++; if (mul_start !== 1'b0 || gnt !== 4'b0001) begin
         fails++; $display("FAIL single_wait start=%b gnt=%b expected 0/0001", mul_start, gnt); end
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b0001 || rsp_product !== 32'd12 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL single_rsp got=%b valid=%b prod=%0d err=%b expected 1/0001/12/0", got, rsp_valid, rsp_product, rsp_err); end
      req[0] = 1'b0;
      @(negedge clk);
      tests++; if (gnt !== 4'b0 || busy !== 1'b0 || rsp_valid !== 4'b0 || mul_arg1 !== 16'd3) begin
         fails++; $display("FAIL single_idle gnt=%b busy=%b valid=%b a1=%0d expected 0/0/0/3", gnt, busy, rsp_valid, mul_arg1); end
   endtask

   task automatic test_two();
      int cyc; bit got, bad;
      pulse_reset();
      set_req(0, 1'b1, 16'd3, 16'd4);
      set_req(2, 1'b1, 16'd5, 16'd6);
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b0001 || rsp_product !== 32'd12) begin
         fails++; $display("FAIL two_first got=%b valid=%b prod=%0d expected 1/0001/12", got, rsp_valid, rsp_product); end
      req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++; if (busy !== 1'b1 || gnt !== 4'b0100) begin
         fails++; $display("FAIL two_gap busy=%b gnt=%b expected 1/0100", busy, gnt); end
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b0100 || rsp_product !== 32'd30 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL two_second got=%b valid=%b prod=%0d err=%b expected 1/0100/30/0", got, rsp_valid, rsp_product, rsp_err); end
      req[2] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      int cyc; bit got, bad;
      logic [31:0] exp_prod [4];
      exp_prod[0] = 32'd10; exp_prod[1] = 32'd22; exp_prod[2] = 32'd36; exp_prod[3] = 32'd52;
      pulse_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i + 1), 16'(i + 10));
      for (int n = 0; n < 8; n++) begin
         wait_rsp(200, cyc, got, bad);
         tests++; if (!got || rsp_valid !== (4'b0001 << (n % 4)) || rsp_product !== exp_prod[n % 4]) begin
            fails++; $display("FAIL rr_op%0d got=%b valid=%b prod=%0d expected valid bit %0d prod=%0d", n, got, rsp_valid, rsp_product, n % 4, exp_prod[n % 4]); end
         tests++; if (bad) begin
            fails++; $display("FAIL rr_onehot%0d gnt=%b not one-hot while busy", n, gnt); end
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_extremes();
      int cyc; bit got, bad;
      set_req(1, 1'b1, 16'hFFFF, 16'hFFFF);
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b0010 || rsp_product !== 32'hFFFE0001 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL max_prod got=%b valid=%b prod=%h err=%b expected 1/0010/fffe0001/0", got, rsp_valid, rsp_product, rsp_err); end
      req[1] = 1'b0;
      @(negedge clk);
      set_req(1, 1'b1, 16'h1234, 16'h0000);
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b0010 || rsp_product !== 32'd0 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL zero_prod got=%b valid=%b prod=%h err=%b expected 1/0010/0/0", got, rsp_valid, rsp_product, rsp_err); end
      req[1] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int cyc; bit got, bad;
      stub_never = 1'b1;
      set_req(2, 1'b1, 16'd7, 16'd8);
      wait_start(50, got);
      tests++; if (!got) begin
         fails++; $display("FAIL to_start mul_start=%b expected 1 within 50 cycles", mul_start); end
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || cyc != TIMEOUT + 1) begin
         fails++; $display("FAIL to_latency got=%b cycles=%0d expected %0d", got, cyc, TIMEOUT + 1); end
      tests++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_product !== 32'd0) begin
         fails++; $display("FAIL to_rsp valid=%b err=%b prod=%h expected 0100/1/0", rsp_valid, rsp_err, rsp_product); end
      req[2] = 1'b0;
      stub_never = 1'b0;
      @(negedge clk);
      set_req(3, 1'b1, 16'd2, 16'd9);
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b1000 || rsp_product !== 32'd18 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL to_recover got=%b valid=%b prod=%0d err=%b expected 1/1000/18/0", got, rsp_valid, rsp_product, rsp_err); end
      req[3] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_wait();
      int cyc; bit got, bad;
      set_req(1, 1'b1, 16'd6, 16'd7);
      wait_start(50, got);
      @(negedge clk);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      tests++; if (gnt !== 4'b0 || busy !== 1'b0 || rsp_valid !== 4'b0 || mul_res_n !== 1'b0) begin
         fails++; $display("FAIL midrst gnt=%b busy=%b valid=%b res_n=%b expected 0/0/0/0", gnt, busy, rsp_valid, mul_res_n); end
      wait_rsp(200, cyc, got, bad);
      tests++; if (!got || rsp_valid !== 4'b0010 || rsp_product !== 32'd42 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL midrst_regrant got=%b valid=%b prod=%0d err=%b expected 1/0010/42/0", got, rsp_valid, rsp_product, rsp_err); end
      req[1] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      stub_never = 1'b0;
      test_reset();
      test_single();
      test_two();
      test_round_robin();
      test_extremes();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
